// File: rtl/blit_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : blit_bus_arbiter
// Brief    : Memory bus arbiter for CPU / blitter / DSP with CPU hold handshake
//            and bounded low-priority blitter bursts.
// Revision : 1.0 - initial release
// ============================================================================
module blit_bus_arbiter #(
    parameter int BURST_MAX   = 16,
    parameter int RELEASE_GAP = 2
) (
    input  logic MasterClock,
    input  logic SRESET,
    input  logic BLTREQ,
    input  logic BLTHIPRI,
    input  logic BLTSAFE,
    input  logic DSPREQ,
    input  logic CPUHLDA,
    output logic HOLD,
    output logic BLTGNT,
    output logic DSPGNT,
    output logic BLTSUSP,
    output logic HLDAERR
);

    localparam int c_CNT_W = $clog2(BURST_MAX + 1);
    localparam int c_GAP_W = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(BURST_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_TERM = c_CNT_W'(BURST_MAX - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(RELEASE_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HWAIT = 3'd1,
        S_BLIT  = 3'd2,
        S_SUSP  = 3'd3,
        S_DSP   = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    typedef enum logic {
        OWN_BLT = 1'b0,
        OWN_DSP = 1'b1
    } owner_t;

    state_t               r_state;
    owner_t               r_owner;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_GAP_W-1:0]   r_gap;
    logic                 r_hold;
    logic                 r_bltgnt;
    logic                 r_dspgnt;
    logic                 r_bltsusp;
    logic                 r_hldaerr;

    state_t               w_state;
    owner_t               w_owner;
    logic [c_CNT_W-1:0]   w_cnt;
    logic [c_CNT_W-1:0]   w_cnt_inc;
    logic [c_GAP_W-1:0]   w_gap;
    logic                 w_hold;
    logic                 w_bltgnt;
    logic                 w_dspgnt;
    logic                 w_bltsusp;
    logic                 w_arb;
    logic                 w_owner_req;

    assign w_cnt_inc   = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_owner_req = (r_owner == OWN_DSP) ? DSPREQ : BLTREQ;

    always_comb begin
        w_state   = r_state;
        w_owner   = r_owner;
        w_cnt     = r_cnt;
        w_gap     = r_gap;
        w_hold    = r_hold;
        w_bltgnt  = r_bltgnt;
        w_dspgnt  = r_dspgnt;
        w_bltsusp = r_bltsusp;
        w_arb     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_arb = 1'b1;
            end
            S_HWAIT: begin
                if (!w_owner_req) begin
                    w_state = S_IDLE;
                    w_hold  = 1'b0;
                end else if (CPUHLDA) begin
                    if (r_owner == OWN_DSP) begin
                        w_state  = S_DSP;
                        w_dspgnt = 1'b1;
                    end else begin
                        w_state  = S_BLIT;
                        w_bltgnt = 1'b1;
                        w_cnt    = '0;
                    end
                end
            end
            S_BLIT: begin
                w_cnt = w_cnt_inc;
                if (!BLTREQ) begin
                    w_state  = S_IDLE;
                    w_hold   = 1'b0;
                    w_bltgnt = 1'b0;
                // The terminal test uses the count including this cycle so the
                // suspend cycle still fits inside the burst budget; >= keeps a
                // burst bounded after a high-priority run saturated the counter.
                end else if (!BLTHIPRI && (DSPREQ || (w_cnt_inc >= c_CNT_TERM))) begin
                    w_state   = S_SUSP;
                    w_bltsusp = 1'b1;
                end
            end
            S_SUSP: begin
                if (!BLTREQ) begin
                    w_state   = S_IDLE;
                    w_hold    = 1'b0;
                    w_bltgnt  = 1'b0;
                    w_bltsusp = 1'b0;
                end else if (BLTSAFE) begin
                    w_bltgnt  = 1'b0;
                    w_bltsusp = 1'b0;
                    if (DSPREQ) begin
                        w_state  = S_DSP;
                        w_owner  = OWN_DSP;
                        w_dspgnt = 1'b1;
                    end else begin
                        w_state = S_GAP;
                        w_hold  = 1'b0;
                        w_gap   = c_GAP_LOAD;
                    end
                end
            end
            S_DSP: begin
                if (!DSPREQ) begin
                    w_dspgnt = 1'b0;
                    if (BLTREQ) begin
                        w_state  = S_BLIT;
                        w_owner  = OWN_BLT;
                        w_bltgnt = 1'b1;
                        w_cnt    = '0;
                    end else begin
                        w_state = S_IDLE;
                        w_hold  = 1'b0;
                    end
                end
            end
            S_GAP: begin
                // Last gap cycle arbitrates directly so HOLD is low for exactly
                // RELEASE_GAP cycles before a pending requester re-holds the CPU.
                if (r_gap == '0) begin
                    w_arb = 1'b1;
                end else begin
                    w_gap = r_gap - 1'b1;
                end
            end
            default: begin
                w_state   = S_IDLE;
                w_hold    = 1'b0;
                w_bltgnt  = 1'b0;
                w_dspgnt  = 1'b0;
                w_bltsusp = 1'b0;
            end
        endcase

        if (w_arb) begin
            w_state   = S_IDLE;
            w_hold    = 1'b0;
            w_bltgnt  = 1'b0;
            w_dspgnt  = 1'b0;
            w_bltsusp = 1'b0;
            if (DSPREQ) begin
                w_state = S_HWAIT;
                w_owner = OWN_DSP;
                w_hold  = 1'b1;
            end else if (BLTREQ) begin
                w_state = S_HWAIT;
                w_owner = OWN_BLT;
                w_hold  = 1'b1;
            end
        end
    end

    always_ff @(posedge MasterClock) begin
        if (SRESET) begin
            r_state   <= S_IDLE;
            r_owner   <= OWN_BLT;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_hold    <= 1'b0;
            r_bltgnt  <= 1'b0;
            r_dspgnt  <= 1'b0;
            r_bltsusp <= 1'b0;
            r_hldaerr <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_owner   <= w_owner;
            r_cnt     <= w_cnt;
            r_gap     <= w_gap;
            r_hold    <= w_hold;
            r_bltgnt  <= w_bltgnt;
            r_dspgnt  <= w_dspgnt;
            r_bltsusp <= w_bltsusp;
            r_hldaerr <= r_hldaerr | ((r_bltgnt | r_dspgnt) & ~CPUHLDA);
        end
    end

    assign HOLD    = r_hold;
    assign BLTGNT  = r_bltgnt;
    assign DSPGNT  = r_dspgnt;
    assign BLTSUSP = r_bltsusp;
    assign HLDAERR = r_hldaerr;

endmodule
`default_nettype wire
